nyq_frame_collector: RTL

//  Receive-side companion of the NYQ phase counter (3-bit down-counter, 7->0, wraps).

---
 rtl/nyq_frame_collector_pkg.sv | 18 +
 rtl/nyq_frame_collector_outreg.sv | 41 ++++
 rtl/nyq_frame_collector.sv | 126 ++++++++++++
 3 files changed

// File: rtl/nyq_frame_collector_pkg.sv
// Shared NYQ receive-side definitions: default widths, collector FSM state type
// and the slot-offset helper for flat frame vectors.
package nyq_pkg;

  localparam int unsigned NYQ_CNT_W    = 3;
  localparam int unsigned NYQ_SAMPLE_W = 12;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } nyq_state_e;

  function automatic int unsigned nyq_slot_lsb(input int unsigned slot,
                                               input int unsigned sample_w);
    return slot * sample_w;
  endfunction

endpackage

// File: rtl/nyq_frame_collector_outreg.sv
// Single-entry valid/ready output register for completed NYQ frames; decides
// load vs. drop on completion and pulses Overflow_SO when a frame is dropped.
module nyq_frame_outreg #(
  parameter int unsigned FRAME_W = 96
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic               Load_SI,
  input  logic [FRAME_W-1:0] Frame_DI,
  output logic [FRAME_W-1:0] Frame_DO,
  output logic               FrameValid_SO,
  input  logic               FrameReady_SI,
  output logic               Overflow_SO
);

  logic accept;

  assign accept = FrameValid_SO && FrameReady_SI;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      Frame_DO      <= '0;
      FrameValid_SO <= 1'b0;
      Overflow_SO   <= 1'b0;
    end else begin
      Overflow_SO <= 1'b0;
      if (Load_SI) begin
        // A frame leaving on this same edge frees the slot for the new one.
        if (!FrameValid_SO || accept) begin
          Frame_DO      <= Frame_DI;
          FrameValid_SO <= 1'b1;
        end else begin
          Overflow_SO <= 1'b1;
        end
      end else if (accept) begin
        FrameValid_SO <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nyq_frame_collector.sv
// Collects one sample per NYQ phase slot (PH_MAX down to 0) into a frame and
// hands it to nyq_frame_outreg. Optional phase checking: NYQ_PHASE_CHECK_EN.
module nyq_frame_collector
  import nyq_pkg::*;
#(
  parameter  int unsigned SAMPLE_W  = NYQ_SAMPLE_W,
  parameter  int unsigned CNT_W     = NYQ_CNT_W,
  localparam int unsigned NUM_SLOTS = 2 ** CNT_W
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RI,
  input  logic [CNT_W-1:0]              Phase_DI,
  input  logic [SAMPLE_W-1:0]           Sample_DI,
  input  logic                          SampleValid_SI,
  output logic [NUM_SLOTS*SAMPLE_W-1:0] Frame_DO,
  output logic                          FrameValid_SO,
  input  logic                          FrameReady_SI,
  output logic                          Overflow_SO,
  output logic                          PhaseErr_SO,
  output logic                          Busy_SO
);

  localparam logic [CNT_W-1:0] PH_MAX  = '1;
  localparam int unsigned      FRAME_W = NUM_SLOTS * SAMPLE_W;

  nyq_state_e                               state_q;
  logic [NUM_SLOTS-1:0][SAMPLE_W-1:0]       asm_q;
  logic [NUM_SLOTS-1:0][SAMPLE_W-1:0]       asm_done;
  logic                                     done;

  // The phase-0 sample is merged combinationally so the frame loads on its edge.
  always_comb begin
    asm_done    = asm_q;
    asm_done[0] = Sample_DI;
  end

  assign Busy_SO = (state_q == ST_COLLECT);

`ifdef NYQ_PHASE_CHECK_EN
  logic [CNT_W-1:0] exp_q;
  logic             phase_err_q;

  assign done = SampleValid_SI && (state_q == ST_COLLECT) &&
                (Phase_DI == exp_q) && (Phase_DI == '0);

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= ST_IDLE;
      asm_q       <= '0;
      exp_q       <= '0;
      phase_err_q <= 1'b0;
    end else begin
      phase_err_q <= 1'b0;
      if (SampleValid_SI) begin
        case (state_q)
          ST_IDLE: begin
            if (Phase_DI == PH_MAX) begin
              asm_q[Phase_DI] <= Sample_DI;
              exp_q           <= PH_MAX - CNT_W'(1);
              state_q         <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (Phase_DI == exp_q) begin
              asm_q[Phase_DI] <= Sample_DI;
              exp_q           <= Phase_DI - CNT_W'(1);
              if (Phase_DI == '0) state_q <= ST_IDLE;
            end else begin
              // Broken sequence: a fresh PH_MAX restarts in place, anything else resyncs via IDLE.
              phase_err_q <= 1'b1;
              if (Phase_DI == PH_MAX) begin
                asm_q[Phase_DI] <= Sample_DI;
                exp_q           <= PH_MAX - CNT_W'(1);
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign PhaseErr_SO = phase_err_q;
`else
  assign done = SampleValid_SI && (state_q == ST_COLLECT) && (Phase_DI == '0);

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q <= ST_IDLE;
      asm_q   <= '0;
    end else if (SampleValid_SI) begin
      case (state_q)
        ST_IDLE: begin
          if (Phase_DI == PH_MAX) begin
            asm_q[Phase_DI] <= Sample_DI;
            state_q         <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          asm_q[Phase_DI] <= Sample_DI;
          if (Phase_DI == '0) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PhaseErr_SO = 1'b0;
`endif

  nyq_frame_outreg #(
    .FRAME_W (FRAME_W)
  ) i_outreg (
    .Clk_CI        (Clk_CI),
    .Rst_RI        (Rst_RI),
    .Load_SI       (done),
    .Frame_DI      (asm_done),
    .Frame_DO      (Frame_DO),
    .FrameValid_SO (FrameValid_SO),
    .FrameReady_SI (FrameReady_SI),
    .Overflow_SO   (Overflow_SO)
  );

endmodule
